// File: rtl/recepcao_medida_if.sv
// rtl/recepcao_medida_if.sv - serial line input and measurement outputs of recepcao_medida
interface recepcao_medida_if;
    logic        rx_serial;
    logic [15:0] temperatura;
    logic [15:0] umidade;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    modport slave (
        input  rx_serial,
        output temperatura,
        output umidade,
        output pronto,
        output erro,
        output db_estado
    );

    modport master (
        output rx_serial,
        input  temperatura,
        input  umidade,
        input  pronto,
        input  erro,
        input  db_estado
    );
endinterface

// File: rtl/recepcao_medida.sv
// rtl/recepcao_medida.sv - 8N1 UART byte receiver feeding a "TTTT,UUUU#" hex frame parser
module recepcao_medida #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic               clock,
    input  logic               reset,
    recepcao_medida_if.slave   io_bus
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        INICIO = 2'd1,
        DADOS  = 2'd2,
        PARADA = 2'd3
    } rx_state_t;

    typedef enum logic [3:0] {
        P_T3  = 4'd0,
        P_T2  = 4'd1,
        P_T1  = 4'd2,
        P_T0  = 4'd3,
        P_SEP = 4'd4,
        P_U3  = 4'd5,
        P_U2  = 4'd6,
        P_U1  = 4'd7,
        P_U0  = 4'd8,
        P_FIM = 4'd9
    } parse_state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    rx_state_t        r_rx_state;
    rx_state_t        w_rx_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_byte;

    logic             w_fall;
    logic             w_half_done;
    logic             w_bit_done;
    logic             w_sample;
    logic             w_byte_valid;
    logic             w_frame_err;

    parse_state_t     r_p_state;
    parse_state_t     w_p_next;
    logic [15:0]      r_temp_sh;
    logic [15:0]      r_hum_sh;
    logic [15:0]      r_temp;
    logic [15:0]      r_hum;
    logic             r_pronto;
    logic             r_erro;

    logic             w_is_hex;
    logic [3:0]       w_nibble;
    logic             w_shift_t;
    logic             w_shift_h;
    logic             w_load;
    logic             w_pronto_n;
    logic             w_erro_n;

    // Synchronizer idles high so releasing reset never looks like a start bit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= io_bus.rx_serial;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_fall      = r_rx_prev & ~r_sync2;
    assign w_half_done = (r_cnt == CNT_W'(HALF_BIT - 1));
    assign w_bit_done  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_state <= OCIOSO;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next    = r_rx_state;
        w_sample     = 1'b0;
        w_byte_valid = 1'b0;
        w_frame_err  = 1'b0;
        case (r_rx_state)
            OCIOSO: begin
                if (w_fall) begin
                    w_rx_next = INICIO;
                end
            end
            INICIO: begin
                if (w_half_done) begin
                    w_rx_next = r_sync2 ? OCIOSO : DADOS;
                end
            end
            DADOS: begin
                if (w_bit_done) begin
                    w_sample = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_rx_next = PARADA;
                    end
                end
            end
            PARADA: begin
                if (w_bit_done) begin
                    w_rx_next    = OCIOSO;
                    w_byte_valid = r_sync2;
                    w_frame_err  = ~r_sync2;
                end
            end
            default: w_rx_next = OCIOSO;
        endcase
    end

    // Counter restarts on every state change and after each data sample
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((r_rx_state == OCIOSO) || (w_rx_next != r_rx_state) || w_sample) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_idx <= 3'd0;
            r_byte    <= 8'h00;
        end else begin
            if (r_rx_state != DADOS) begin
                r_bit_idx <= 3'd0;
            end else if (w_sample) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_sample) begin
                r_byte <= {r_sync2, r_byte[7:1]};
            end
        end
    end

    always_comb begin
        w_is_hex = 1'b0;
        w_nibble = 4'h0;
        if ((r_byte >= 8'h30) && (r_byte <= 8'h39)) begin
            w_is_hex = 1'b1;
            w_nibble = r_byte[3:0];
        end else if (((r_byte >= 8'h41) && (r_byte <= 8'h46)) ||
                     ((r_byte >= 8'h61) && (r_byte <= 8'h66))) begin
            w_is_hex = 1'b1;
            w_nibble = r_byte[3:0] + 4'd9;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_p_state <= P_T3;
        end else begin
            r_p_state <= w_p_next;
        end
    end

    // '#' outside FIM restarts the frame, so the next byte is taken as T3
    always_comb begin
        w_p_next   = r_p_state;
        w_shift_t  = 1'b0;
        w_shift_h  = 1'b0;
        w_load     = 1'b0;
        w_pronto_n = 1'b0;
        w_erro_n   = 1'b0;
        if (w_frame_err) begin
            w_erro_n = 1'b1;
            w_p_next = P_T3;
        end else if (w_byte_valid) begin
            if (r_byte == 8'h23) begin
                w_p_next = P_T3;
                if (r_p_state == P_FIM) begin
                    w_load     = 1'b1;
                    w_pronto_n = 1'b1;
                end else begin
                    w_erro_n = 1'b1;
                end
            end else begin
                case (r_p_state)
                    P_T3, P_T2, P_T1, P_T0: begin
                        if (w_is_hex) begin
                            w_shift_t = 1'b1;
                            w_p_next  = parse_state_t'(r_p_state + 4'd1);
                        end else begin
                            w_erro_n = 1'b1;
                            w_p_next = P_T3;
                        end
                    end
                    P_SEP: begin
                        if (r_byte == 8'h2C) begin
                            w_p_next = P_U3;
                        end else begin
                            w_erro_n = 1'b1;
                            w_p_next = P_T3;
                        end
                    end
                    P_U3, P_U2, P_U1, P_U0: begin
                        if (w_is_hex) begin
                            w_shift_h = 1'b1;
                            w_p_next  = parse_state_t'(r_p_state + 4'd1);
                        end else begin
                            w_erro_n = 1'b1;
                            w_p_next = P_T3;
                        end
                    end
                    default: begin
                        w_erro_n = 1'b1;
                        w_p_next = P_T3;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_temp_sh <= 16'h0000;
            r_hum_sh  <= 16'h0000;
            r_temp    <= 16'h0000;
            r_hum     <= 16'h0000;
            r_pronto  <= 1'b0;
            r_erro    <= 1'b0;
        end else begin
            if (w_shift_t) begin
                r_temp_sh <= {r_temp_sh[11:0], w_nibble};
            end
            if (w_shift_h) begin
                r_hum_sh <= {r_hum_sh[11:0], w_nibble};
            end
            if (w_load) begin
                r_temp <= r_temp_sh;
                r_hum  <= r_hum_sh;
            end
            r_pronto <= w_pronto_n;
            r_erro   <= w_erro_n;
        end
    end

    assign io_bus.temperatura = r_temp;
    assign io_bus.umidade     = r_hum;
    assign io_bus.pronto      = r_pronto;
    assign io_bus.erro        = r_erro;
    assign io_bus.db_estado   = r_p_state;

endmodule

// File: tb/tb_recepcao_medida.sv
// tb/tb_recepcao_medida.sv - directed-frame bench for recepcao_medida
module tb_recepcao_medida;

    localparam int CLKS     = 16;
    localparam int HALF_BIT = CLKS / 2;
    // Start edge to pronto: sync + edge detect, half bit, 8 data bits and the stop bit
    localparam int LATENCY  = 3 + HALF_BIT + 9 * CLKS;

    logic clock = 1'b0;
    logic reset = 1'b1;

    recepcao_medida_if bus ();

    recepcao_medida #(.CLKS_PER_BIT(CLKS)) dut (
        .clock  (clock),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_start = 0;

    int          n_pronto = 0;
    int          n_erro   = 0;
    int          n_both   = 0;
    logic [15:0] cap_t[$];
    logic [15:0] cap_h[$];
    int          cap_cyc[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.pronto) begin
            n_pronto++;
            cap_t.push_back(bus.temperatura);
            cap_h.push_back(bus.umidade);
            cap_cyc.push_back(cyc);
        end
        if (bus.erro) n_erro++;
        if (bus.pronto && bus.erro) n_both++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int rst_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rx_serial = frame[i];
            if (i == 0) last_start = cyc;
            if (i == rst_bit) reset = 1'b1;
            repeat (CLKS) @(negedge clock);
        end
    endtask

    task automatic send_str(input string s, input int rst_byte);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1, (i == rst_byte) ? 4 : -1);
        end
    endtask

    task automatic idle(input int n);
        bus.rx_serial = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.rx_serial = 1'b1;
        repeat (5) @(negedge clock);
        checks++; if (bus.temperatura !== 16'h0000) begin errors++; $display("FAIL reset_temp got=%h exp=0000", bus.temperatura); end
        checks++; if (bus.umidade !== 16'h0000) begin errors++; $display("FAIL reset_hum got=%h exp=0000", bus.umidade); end
        checks++; if (bus.pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto got=%b exp=0", bus.pronto); end
        checks++; if (bus.erro !== 1'b0) begin errors++; $display("FAIL reset_erro got=%b exp=0", bus.erro); end
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.db_estado); end
        reset = 1'b0;
        idle(20);
    endtask

    task automatic test_single_frame;
        int p0, e0, q0;
        p0 = n_pronto; e0 = n_erro; q0 = cap_cyc.size();
        send_str("1524,", -1);
        checks++; if (bus.db_estado !== 4'd5) begin errors++; $display("FAIL partial_state got=%0d exp=5", bus.db_estado); end
        checks++; if (bus.temperatura !== 16'h0000) begin errors++; $display("FAIL partial_temp got=%h exp=0000", bus.temperatura); end
        send_str("095E#", -1);
        idle(CLKS);
        checks++; if (n_pronto - p0 !== 1) begin errors++; $display("FAIL single_pronto got=%0d exp=1", n_pronto - p0); end
        checks++; if (n_erro - e0 !== 0) begin errors++; $display("FAIL single_erro got=%0d exp=0", n_erro - e0); end
        checks++; if (bus.temperatura !== 16'h1524) begin errors++; $display("FAIL single_temp got=%h exp=1524", bus.temperatura); end
        checks++; if (bus.umidade !== 16'h095E) begin errors++; $display("FAIL single_hum got=%h exp=095e", bus.umidade); end
        checks++;
        if (cap_cyc.size() <= q0) begin
            errors++; $display("FAIL single_latency got=no_pulse exp=%0d", LATENCY);
        end else if (cap_cyc[q0] - last_start !== LATENCY) begin
            errors++; $display("FAIL single_latency got=%0d exp=%0d", cap_cyc[q0] - last_start, LATENCY);
        end
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL single_state got=%0d exp=0", bus.db_estado); end
    endtask

    task automatic test_back_to_back;
        int p0, e0, q0;
        p0 = n_pronto; e0 = n_erro; q0 = cap_t.size();
        send_str("abcd,ef01#0000,FFFF#", -1);
        idle(CLKS);
        checks++; if (n_pronto - p0 !== 2) begin errors++; $display("FAIL b2b_pronto got=%0d exp=2", n_pronto - p0); end
        checks++; if (n_erro - e0 !== 0) begin errors++; $display("FAIL b2b_erro got=%0d exp=0", n_erro - e0); end
        checks++;
        if (cap_t.size() < q0 + 1) begin
            errors++; $display("FAIL b2b_first got=no_pulse exp=abcd/ef01");
        end else if (cap_t[q0] !== 16'hABCD || cap_h[q0] !== 16'hEF01) begin
            errors++; $display("FAIL b2b_first got=%h/%h exp=abcd/ef01", cap_t[q0], cap_h[q0]);
        end
        checks++; if (bus.temperatura !== 16'h0000) begin errors++; $display("FAIL b2b_temp got=%h exp=0000", bus.temperatura); end
        checks++; if (bus.umidade !== 16'hFFFF) begin errors++; $display("FAIL b2b_hum got=%h exp=ffff", bus.umidade); end
    endtask

    task automatic test_content_error;
        int p0, e0;
        p0 = n_pronto; e0 = n_erro;
        // 'G' in T1, ',' then arriving in T2, '#' in SEP: three rejections
        send_str("12G4,0000#", -1);
        idle(CLKS);
        checks++; if (n_erro - e0 !== 3) begin errors++; $display("FAIL content_erro got=%0d exp=3", n_erro - e0); end
        checks++; if (n_pronto - p0 !== 0) begin errors++; $display("FAIL content_pronto got=%0d exp=0", n_pronto - p0); end
        checks++; if (bus.temperatura !== 16'h0000) begin errors++; $display("FAIL content_temp got=%h exp=0000", bus.temperatura); end
        checks++; if (bus.umidade !== 16'hFFFF) begin errors++; $display("FAIL content_hum got=%h exp=ffff", bus.umidade); end
        p0 = n_pronto;
        send_str("BEEF,CAFE#", -1);
        idle(CLKS);
        checks++; if (n_pronto - p0 !== 1) begin errors++; $display("FAIL recover_pronto got=%0d exp=1", n_pronto - p0); end
        checks++; if (bus.temperatura !== 16'hBEEF) begin errors++; $display("FAIL recover_temp got=%h exp=beef", bus.temperatura); end
        checks++; if (bus.umidade !== 16'hCAFE) begin errors++; $display("FAIL recover_hum got=%h exp=cafe", bus.umidade); end
    endtask

    task automatic test_framing_error;
        int p0, e0;
        p0 = n_pronto; e0 = n_erro;
        send_str("9", -1);
        send_byte(8'h35, 1'b0, -1);
        idle(2 * CLKS);
        checks++; if (n_erro - e0 !== 1) begin errors++; $display("FAIL framing_erro got=%0d exp=1", n_erro - e0); end
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL framing_state got=%0d exp=0", bus.db_estado); end
        send_str("0001,0002#", -1);
        idle(CLKS);
        checks++; if (n_erro - e0 !== 1) begin errors++; $display("FAIL framing_total_erro got=%0d exp=1", n_erro - e0); end
        checks++; if (n_pronto - p0 !== 1) begin errors++; $display("FAIL framing_pronto got=%0d exp=1", n_pronto - p0); end
        checks++; if (bus.temperatura !== 16'h0001) begin errors++; $display("FAIL framing_temp got=%h exp=0001", bus.temperatura); end
        checks++; if (bus.umidade !== 16'h0002) begin errors++; $display("FAIL framing_hum got=%h exp=0002", bus.umidade); end
    endtask

    task automatic test_glitch;
        int p0, e0;
        p0 = n_pronto; e0 = n_erro;
        idle(CLKS);
        bus.rx_serial = 1'b0;
        repeat (HALF_BIT / 2 + 1) @(negedge clock);
        idle(3 * CLKS);
        checks++; if (n_erro - e0 !== 0) begin errors++; $display("FAIL glitch_erro got=%0d exp=0", n_erro - e0); end
        checks++; if (n_pronto - p0 !== 0) begin errors++; $display("FAIL glitch_pronto got=%0d exp=0", n_pronto - p0); end
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL glitch_state got=%0d exp=0", bus.db_estado); end
        send_str("0A0B,0C0D#", -1);
        idle(CLKS);
        checks++; if (n_pronto - p0 !== 1) begin errors++; $display("FAIL glitch_next_pronto got=%0d exp=1", n_pronto - p0); end
        checks++; if (bus.temperatura !== 16'h0A0B) begin errors++; $display("FAIL glitch_next_temp got=%h exp=0a0b", bus.temperatura); end
        checks++; if (bus.umidade !== 16'h0C0D) begin errors++; $display("FAIL glitch_next_hum got=%h exp=0c0d", bus.umidade); end
    endtask

    task automatic test_reset_mid_frame;
        int p0, e0;
        p0 = n_pronto; e0 = n_erro;
        send_str("1111,2222#", 5);
        idle(CLKS);
        checks++; if (bus.temperatura !== 16'h0000) begin errors++; $display("FAIL midrst_temp got=%h exp=0000", bus.temperatura); end
        checks++; if (bus.umidade !== 16'h0000) begin errors++; $display("FAIL midrst_hum got=%h exp=0000", bus.umidade); end
        checks++; if (bus.db_estado !== 4'd0) begin errors++; $display("FAIL midrst_state got=%0d exp=0", bus.db_estado); end
        reset = 1'b0;
        idle(2 * CLKS);
        checks++; if (n_erro - e0 !== 0) begin errors++; $display("FAIL midrst_erro got=%0d exp=0", n_erro - e0); end
        checks++; if (n_pronto - p0 !== 0) begin errors++; $display("FAIL midrst_pronto got=%0d exp=0", n_pronto - p0); end
        send_str("00A5,5A00#", -1);
        idle(CLKS);
        checks++; if (n_pronto - p0 !== 1) begin errors++; $display("FAIL midrst_next_pronto got=%0d exp=1", n_pronto - p0); end
        checks++; if (bus.temperatura !== 16'h00A5) begin errors++; $display("FAIL midrst_next_temp got=%h exp=00a5", bus.temperatura); end
        checks++; if (bus.umidade !== 16'h5A00) begin errors++; $display("FAIL midrst_next_hum got=%h exp=5a00", bus.umidade); end
        checks++; if (n_erro - e0 !== 0) begin errors++; $display("FAIL midrst_next_erro got=%0d exp=0", n_erro - e0); end
    endtask

    initial begin
        bus.rx_serial = 1'b1;
        @(negedge clock);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_content_error();
        test_framing_error();
        test_glitch();
        test_reset_mid_frame();
        checks++; if (n_both !== 0) begin errors++; $display("FAIL pronto_and_erro got=%0d exp=0", n_both); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
